// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: grants the single memory port to the fetch (I) or
// load/store (D) requester, runs a req/ready handshake, and converts a stalled
// access into an error acknowledge after a bounded number of wait cycles.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic          i_err,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          last_was_d_q, last_was_d_d;  // 1: D was served most recently
    logic          m_we_q, m_we_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic          i_elig, d_elig;

    // A requester still sees its req high during its own ack cycle; mask it there.
    assign i_elig    = i_req & ~i_ack_q;
    assign d_elig    = d_req & ~d_ack_q;
    assign timer_inc = timer_q + TW'(1);

    // Next-state: arbitration in idle, completion or timeout while granted.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_was_d_d = last_was_d_q;
        m_we_d       = m_we_q;
        m_be_d       = m_be_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            StIdle: begin
                if (i_elig && (!d_elig || last_was_d_q)) begin
                    state_d      = StGntI;
                    last_was_d_d = 1'b0;
                    m_we_d       = 1'b0;
                    m_be_d       = 4'b1111;
                    m_addr_d     = i_addr;
                    m_wdata_d    = '0;
                end else if (d_elig) begin
                    state_d      = StGntD;
                    last_was_d_d = 1'b1;
                    m_we_d       = d_we;
                    m_be_d       = d_be;
                    m_addr_d     = d_addr;
                    m_wdata_d    = d_wdata;
                end
            end
            StGntI, StGntD: begin
                if (m_ready) begin
                    state_d = StIdle;
                    timer_d = '0;
                    if (state_q == StGntI) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_rdata;
                    end
                end else if (timer_inc == TW'(TIMEOUT)) begin
                    state_d = StIdle;
                    timer_d = '0;
                    if (state_q == StGntI) begin
                        i_ack_d   = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            last_was_d_q <= 1'b1;
            m_we_q       <= 1'b0;
            m_be_q       <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_was_d_q <= last_was_d_d;
            m_we_q       <= m_we_d;
            m_be_q       <= m_be_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign m_req   = busy;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts grants and completions into queues; a monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 5;
    localparam int          NCYC    = 3000;
    localparam int          NDRAIN  = 60;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [3:0]    d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack, d_err;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          busy;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } grant_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } done_t;

    grant_t gq[$];
    done_t  iq[$];
    done_t  dq[$];

    int total = 0;
    int bad   = 0;

    bit mon_on     = 1'b0;
    bit i_ack_seen = 1'b0;
    bit d_ack_seen = 1'b0;
    int rst_chk    = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state (transaction level)
    bit mdl_active = 1'b0, mdl_is_d = 1'b0, last_d = 1'b1, stop = 1'b0, rst_done = 1'b0;
    int mdl_start, mdl_lat, mdl_wait, free_from, ack_cyc_i = -1, ack_cyc_d = -1;
    logic [3:0] be_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = $urandom() & 32'hffff_fffc;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_be    = be_tab[$urandom_range(0, 6)];
        d_addr  = $urandom();
        d_wdata = $urandom();
    endtask

    task automatic finish_access(input logic [31:0] rd, input logic err, input int c);
        done_t d;
        d.rdata = rd;
        d.err   = err;
        d.cyc   = c + 1;
        if (mdl_is_d) begin
            dq.push_back(d);
            ack_cyc_d = c + 1;
        end else begin
            iq.push_back(d);
            ack_cyc_i = c + 1;
        end
        mdl_active = 1'b0;
        free_from  = c + 1;
    endtask

    // Stimulus plus model: drives requesters and memory, pushes expectations.
    initial begin
        int c, mode;
        bit ei, ed;
        grant_t g;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({m_req, m_we, m_be, i_ack, d_ack, i_err, d_err, busy}), 64'd0);
        check("rst_maddr", 64'(m_addr), 64'd0);
        check("rst_mwdata", 64'(m_wdata), 64'd0);
        check("rst_irdata", 64'(i_rdata), 64'd0);
        check("rst_drdata", 64'(d_rdata), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        free_from = cyc;
        mon_on = 1'b1;
        new_i();
        new_d();
        for (int n = 0; n < NCYC + NDRAIN; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #2;
            end
            c    = cyc;
            stop = (n >= NCYC);
            if (!rst_done && n >= NCYC / 2 && n < NCYC && mdl_active && !mdl_is_d &&
                mdl_start < c) begin
                // Reset in the middle of a fetch access; it must be abandoned silently.
                rst      = 1'b1;
                rst_done = 1'b1;
                gq.delete();
                iq.delete();
                dq.delete();
                m_ready  = 1'b1;
                m_rdata  = $urandom();
                rst_chk  = c + 1;
                @(posedge clk);
                #2;
                rst        = 1'b0;
                c          = cyc;
                n++;
                mdl_active = 1'b0;
                free_from  = c;
                last_d     = 1'b1;
                ack_cyc_i  = -1;
                ack_cyc_d  = -1;
                new_i();
                new_d();
            end else if (n > 0) begin
                if (i_req) begin
                    if (i_ack_seen) begin
                        if (!stop && $urandom_range(0, 1) == 1) new_i();
                        else i_req = 1'b0;
                    end
                end else if (!stop && $urandom_range(0, 2) == 0) new_i();
                if (d_req) begin
                    if (d_ack_seen) begin
                        if (!stop && $urandom_range(0, 1) == 1) new_d();
                        else d_req = 1'b0;
                    end
                end else if (!stop && $urandom_range(0, 2) == 0) new_d();
            end
            // Memory responder
            if (mdl_active && mdl_start <= c) begin
                if (mdl_start == c) begin
                    mode = int'($urandom_range(0, 3));
                    case (mode)
                        0: mdl_lat = 0;
                        1: mdl_lat = int'($urandom_range(1, TIMEOUT - 1));
                        2: mdl_lat = TIMEOUT - 1;
                        default: mdl_lat = TIMEOUT;
                    endcase
                end
                m_rdata = $urandom();
                if (mdl_wait == mdl_lat) begin
                    m_ready = 1'b1;
                    finish_access(m_rdata, 1'b0, c);
                end else begin
                    m_ready = 1'b0;
                    mdl_wait++;
                    if (mdl_wait == TIMEOUT) finish_access(32'd0, 1'b1, c);
                end
            end else begin
                m_ready = 1'($urandom_range(0, 1));
                m_rdata = $urandom();
            end
            // Arbitration: alternate on ties, never regrant in the requester's ack cycle
            if (!mdl_active && c >= free_from) begin
                ei = i_req && (ack_cyc_i != c);
                ed = d_req && (ack_cyc_d != c);
                if (ei || ed) begin
                    g.is_d = !(ei && (!ed || last_d));
                    if (g.is_d) begin
                        g.addr = d_addr; g.we = d_we; g.be = d_be; g.wdata = d_wdata;
                    end else begin
                        g.addr = i_addr; g.we = 1'b0; g.be = 4'b1111; g.wdata = 32'd0;
                    end
                    g.cyc = c + 1;
                    gq.push_back(g);
                    last_d     = g.is_d;
                    mdl_active = 1'b1;
                    mdl_is_d   = g.is_d;
                    mdl_start  = c + 1;
                    mdl_wait   = 0;
                end
            end
        end
        repeat (2) @(negedge clk);
        check("drain_grants", 64'(gq.size()), 64'd0);
        check("drain_i", 64'(iq.size()), 64'd0);
        check("drain_d", 64'(dq.size()), 64'd0);
        check("rst_test_reached", 64'(rst_done), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: pops expectations whenever the DUT starts an access or acks.
    initial begin
        bit     prev_mreq = 1'b0;
        bit     have_cur = 1'b0;
        grant_t cur, g;
        done_t  e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                i_ack_seen = i_ack;
                d_ack_seen = d_ack;
                if (rst_chk == cyc) begin
                    check("rst_mid_mreq", 64'(m_req), 64'd0);
                    check("rst_mid_busy", 64'(busy), 64'd0);
                    check("rst_mid_ack", 64'({i_ack, d_ack}), 64'd0);
                end
                check("ack_exclusive", 64'(i_ack & d_ack), 64'd0);
                check("err_without_ack", 64'({i_err & ~i_ack, d_err & ~d_ack}), 64'd0);
                if (m_req && !prev_mreq) begin
                    if (gq.size() == 0) begin
                        check("unexpected_access", 64'd1, 64'd0);
                        have_cur = 1'b0;
                    end else begin
                        g = gq.pop_front();
                        check("grant_cycle", 64'(cyc), 64'(g.cyc));
                        cur      = g;
                        have_cur = 1'b1;
                    end
                end else if (!m_req && gq.size() > 0 && gq[0].cyc <= cyc) begin
                    check("missing_access", 64'd0, 64'd1);
                    void'(gq.pop_front());
                end
                if (m_req && have_cur) begin
                    check("m_addr", 64'(m_addr), 64'(cur.addr));
                    check("m_ctrl", 64'({m_we, m_be, m_wdata}), 64'({cur.we, cur.be, cur.wdata}));
                end
                prev_mreq = m_req;
                if (i_ack) begin
                    if (iq.size() == 0) check("unexpected_i_ack", 64'd1, 64'd0);
                    else begin
                        e = iq.pop_front();
                        check("i_ack_cycle", 64'(cyc), 64'(e.cyc));
                        check("i_rdata", 64'(i_rdata), 64'(e.rdata));
                        check("i_err", 64'(i_err), 64'(e.err));
                    end
                end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
                    check("missing_i_ack", 64'd0, 64'd1);
                    void'(iq.pop_front());
                end
                if (d_ack) begin
                    if (dq.size() == 0) check("unexpected_d_ack", 64'd1, 64'd0);
                    else begin
                        e = dq.pop_front();
                        check("d_ack_cycle", 64'(cyc), 64'(e.cyc));
                        check("d_rdata", 64'(d_rdata), 64'(e.rdata));
                        check("d_err", 64'(d_err), 64'(e.err));
                    end
                end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                    check("missing_d_ack", 64'd0, 64'd1);
                    void'(dq.pop_front());
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port of the multicycle core between the instruction-fetch requester (I) and the load/store requester (D). It runs a request/ready handshake toward memory and supports variable-latency memory. A bounded wait timeout turns a hung access into an error acknowledge. It sits between the control FSM / datapath and the unified instruction/data memory.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles m_req may stay high without m_ready before an error completion (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held with stable i_addr until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch completed by timeout (valid with i_ack)
- i_rdata  out  DW  fetch data, valid with i_ack, held until next I completion
- d_req  in  1  load/store request, held with stable fields until d_ack
- d_we  in  1  1 = store
- d_be  in  4  byte enables (sb/sh/sw)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  data completed by timeout (valid with d_ack)
- d_rdata  out  DW  load data, valid with d_ack, held until next D completion
- m_req  out  1  memory request
- m_we, m_be, m_addr, m_wdata  out  1/4/AW/DW  registered copies of the granted request
- m_rdata  in  DW  memory read data, sampled when m_ready=1
- m_ready  in  1  memory completion for current m_req
- busy  out  1  state != IDLE

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE: sample requests (masking any requester whose ack is high this cycle).
  - Only one valid request: grant it.
  - Both valid: grant the requester not served last. last_grant resets to D, so the first tie after reset goes to I.
  - On grant: latch the request fields into m_* (I grant: m_we=0, m_be=4'b1111, m_wdata=0), set last_grant, go to GNT_x.
- GNT_x: m_req=1.
  - m_ready=1: capture m_rdata into x_rdata, pulse x_ack (x_err=0), clear timer, go IDLE.
  - m_ready=0: increment timer. When timer reaches TIMEOUT: pulse x_ack with x_err=1, x_rdata=0, go IDLE.
- Requester inputs are ignored outside the IDLE sample; m_* never change while m_req=1.
- Timer width: $clog2(TIMEOUT+1); it never wraps, since it is cleared on every exit from GNT_x.
- Stores: m_rdata is still captured into d_rdata on completion; the D side ignores it.
- Reset: state=IDLE, last_grant=D, timer=0. All outputs 0: m_req, m_we, m_be, m_addr, m_wdata, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, busy.
- Reset mid-access: m_req drops at the next edge, no ack is issued, and the interrupted access is abandoned.

## Timing
- Request seen in IDLE at cycle N → m_req=1 from N+1.
- m_ready=1 in cycle N+k (k≥1) → x_ack=1 in cycle N+k+1; state is IDLE that same cycle.
- Minimum request-to-ack latency: 2 cycles (zero-wait memory).
- Earliest next grant: sampled in the cycle after the ack cycle. Same-requester back-to-back throughput is one access per 3 cycles with zero-wait memory.
- Timeout: m_req high for exactly TIMEOUT cycles with m_ready=0 → ack+err in the next cycle.
- m_ready while m_req=0 is ignored.
- x_ack and x_err are single-cycle pulses; i_ack and d_ack are never high in the same cycle.

## Test plan
- Fetch only, zero-wait memory: i_req=1, i_addr=0x100 at cycle 0, m_ready=1 at cycle 1 with m_rdata=0xDEADBEEF → m_addr=0x100, m_req=1 at cycle 1; i_ack=1, i_rdata=0xDEADBEEF at cycle 2; d_ack never high.
- Store with wait states: d_req, d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0x1234; m_ready high after 3 wait cycles → m_we=1, m_be=4'b0011 held constant for all 4 m_req cycles; d_ack one cycle after m_ready.
- Tie after reset, both held continuously: first grant I; then D, I, D alternating, each ack 2 cycles after its grant.
- Timeout: TIMEOUT=4, d_req load, m_ready stuck 0 → m_req high for exactly 4 cycles, then d_ack=1, d_err=1, d_rdata=0; next access completes normally with d_err=0.
- Reset mid-access: assert rst during GNT_I → next cycle m_req=0, busy=0, no i_ack; after release a simultaneous request goes to I.
- m_ready=1 while IDLE with no requests → no ack, no state change.
